inst_cache_loader: RTL and testbench



---
 rtl/inst_loader_pkg.sv | 27 ++
 rtl/inst_cache_loader.sv | 159 +++++++++++++++
 tb/tb_inst_cache_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction cache loader.
// The read-back states exist only when INST_LOADER_VERIFY_EN is defined.
package inst_loader_pkg;

  localparam int DEPTH_WORDS_DEF = 4096;
  localparam int CNT_W_DEF       = 13;
  localparam int WORD_ADDR_W     = 30;

`ifdef INST_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RD_ISSUE,
    ST_RD_CMP,
    ST_DONE,
    ST_ERR
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DONE,
    ST_ERR
  } state_e;
`endif

endpackage

// File: rtl/inst_cache_loader.sv
// Streams instruction words into the instruction cache debug write port and holds the CPU until resident.
// Optional read-back verification of every word is enabled by defining INST_LOADER_VERIFY_EN.
module inst_cache_loader
  import inst_loader_pkg::*;
#(
  parameter int DEPTH_WORDS   = DEPTH_WORDS_DEF,
  parameter int CNT_W         = CNT_W_DEF,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [WORD_ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]       word_count,
  input  logic                   in_valid,
  input  logic [31:0]            in_data,
  output logic                   in_ready,
  output logic                   cache_write_en,
  output logic [WORD_ADDR_W-1:0] cache_debug_addr,
  output logic [31:0]            cache_debug_input,
  input  logic [31:0]            cache_debug_data,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [CNT_W-1:0]       words_done
);

  localparam int SUM_W = CNT_W + 18;

  state_e                 state_q;
  logic [WORD_ADDR_W-1:0] addr_q, addr_d, dbg_addr_q;
  logic [CNT_W-1:0]       remain_q, remain_d, words_done_q, words_done_d;
  logic [31:0]            dbg_in_q;
  logic                   hold_q, busy_q, done_q, error_q;
  logic                   accept, present, last;
  logic [SUM_W-1:0]       end_addr;
  logic                   range_fault;

  assign in_ready = (state_q == ST_LOAD);
  assign accept   = in_ready & in_valid;

`ifdef INST_LOADER_VERIFY_EN
  logic [31:0] word_q;
  assign present = accept | (state_q == ST_RD_ISSUE);
`else
  logic unused_rd;
  assign unused_rd = ^cache_debug_data;
  assign present   = accept;
`endif

  // Address and data lines only move while the cache is actually being driven
  assign cache_write_en    = accept;
  assign cache_debug_addr  = present ? addr_q : dbg_addr_q;
  assign cache_debug_input = accept ? in_data : dbg_in_q;

  assign end_addr    = SUM_W'(base_addr) + SUM_W'(word_count);
  assign range_fault = end_addr > SUM_W'(DEPTH_WORDS);

  assign addr_d       = addr_q + WORD_ADDR_W'(1);
  assign remain_d     = remain_q - CNT_W'(1);
  assign words_done_d = words_done_q + CNT_W'(1);
  assign last         = (remain_q == CNT_W'(1));

  assign cpu_hold   = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign words_done = words_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      dbg_addr_q   <= '0;
      dbg_in_q     <= '0;
      remain_q     <= '0;
      words_done_q <= '0;
      hold_q       <= HOLD_AT_RESET;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef INST_LOADER_VERIFY_EN
      word_q       <= '0;
`endif
    end else begin
      if (present) dbg_addr_q <= addr_q;
      if (accept)  dbg_in_q   <= in_data;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            hold_q       <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            words_done_q <= '0;
            addr_q       <= base_addr;
            remain_q     <= word_count;
            if (word_count == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else if (range_fault) begin
              state_q <= ST_ERR;
              error_q <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
              busy_q  <= 1'b1;
            end
          end
        end
`ifdef INST_LOADER_VERIFY_EN
        ST_LOAD: begin
          if (accept) begin
            word_q  <= in_data;
            state_q <= ST_RD_ISSUE;
          end
        end
        ST_RD_ISSUE: state_q <= ST_RD_CMP;
        // The cache data presented now is the word captured at the RD_ISSUE edge
        ST_RD_CMP: begin
          if (cache_debug_data == word_q) begin
            addr_q       <= addr_d;
            remain_q     <= remain_d;
            words_done_q <= words_done_d;
            if (last) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= ST_LOAD;
            end
          end else begin
            state_q <= ST_ERR;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
          end
        end
`else
        ST_LOAD: begin
          if (accept) begin
            addr_q       <= addr_d;
            remain_q     <= remain_d;
            words_done_q <= words_done_d;
            if (last) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_cache_loader.sv
// Self-checking bench for inst_cache_loader with a behavioural cache model and outcome model.
// Expectations adapt to the INST_LOADER_VERIFY_EN build option.
module tb_inst_cache_loader;

`ifdef INST_LOADER_VERIFY_EN
  localparam int  CYC_PER_WORD = 3;
  localparam bit  VERIFY       = 1'b1;
`else
  localparam int  CYC_PER_WORD = 1;
  localparam bit  VERIFY       = 1'b0;
`endif
  localparam int DEPTH = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [29:0] base_addr = '0;
  logic [12:0] word_count = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, cache_write_en, cpu_hold, busy, done, error;
  logic [29:0] cache_debug_addr;
  logic [31:0] cache_debug_input, cache_debug_data;
  logic [12:0] words_done;

  inst_cache_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .cache_write_en(cache_write_en),
    .cache_debug_addr(cache_debug_addr), .cache_debug_input(cache_debug_input),
    .cache_debug_data(cache_debug_data), .cpu_hold(cpu_hold), .busy(busy), .done(done),
    .error(error), .words_done(words_done)
  );

  always #5 clk = ~clk;

  // Cache model: word-addressed store with one-cycle registered read and an injectable bad word
  typedef struct { int addr; logic [31:0] data; } wr_t;
  logic [31:0] mem [0:DEPTH-1];
  wr_t         wlog[$];
  bit          corrupt_en = 1'b0;
  int          corrupt_addr = 0;

  always @(posedge clk) begin
    if (cache_write_en) begin
      mem[cache_debug_addr[11:0]] <= cache_debug_input;
      wlog.push_back('{int'(cache_debug_addr), cache_debug_input});
    end
    cache_debug_data <= (corrupt_en && int'(cache_debug_addr) == corrupt_addr)
                        ? 32'hdeadbeef : mem[cache_debug_addr[11:0]];
  end

  int total = 0;
  int bad   = 0;
  logic [31:0] stim_q[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 0);
    checkOutput({tag, ".write_en"}, 32'(cache_write_en), 0);
    checkOutput({tag, ".busy"}, 32'(busy), 0);
    checkOutput({tag, ".done"}, 32'(done), 0);
    checkOutput({tag, ".error"}, 32'(error), 0);
    checkOutput({tag, ".addr"}, 32'(cache_debug_addr), 0);
    checkOutput({tag, ".input"}, cache_debug_input, 0);
    checkOutput({tag, ".words_done"}, 32'(words_done), 0);
    checkOutput({tag, ".cpu_hold"}, 32'(cpu_hold), 1);
  endtask

  // Outcome predicted from the load rules alone
  function automatic void model(input int base, input int count, input bit cor_en, input int cor_addr,
                                output bit e_done, output bit e_err, output int e_words,
                                output int e_writes);
    e_done = 1'b0; e_err = 1'b0; e_words = 0; e_writes = 0;
    if (count == 0) e_done = 1'b1;
    else if (base + count > DEPTH) e_err = 1'b1;
    else begin
      e_done = 1'b1; e_words = count; e_writes = count;
      if (VERIFY && cor_en && cor_addr >= base && cor_addr < base + count) begin
        e_done = 1'b0; e_err = 1'b1;
        e_words = cor_addr - base; e_writes = cor_addr - base + 1;
      end
    end
  endfunction

  // Feeds stim_q from a negedge with state already past the start edge
  task automatic applyStimulus(input int max_cycles, input bit toggle, input int poke,
                               output int accepted, output int cycles);
    int idx = 0;
    cycles = 0;
    while (!(done || error) && cycles < max_cycles) begin
      if (cycles == poke) begin
        start = 1'b1; base_addr = '0; word_count = 13'd1;
      end else start = 1'b0;
      in_valid = (idx < stim_q.size()) && (toggle ? ($urandom_range(0, 1) == 1) : 1'b1);
      in_data  = (idx < stim_q.size()) ? stim_q[idx] : $urandom;
      #1;
      if (in_valid && in_ready) idx++;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    in_valid = 1'b0;
    accepted = idx;
    if (cycles >= max_cycles) checkOutput("timeout", 32'(cycles), 32'(max_cycles - 1));
  endtask

  task automatic runCase(input string tag, input int base, input int count, input bit toggle,
                         input bit fixed, input bit cor_en, input int cor_addr, input int poke,
                         input bit e_done, input bit e_err, input int e_words, input int e_writes,
                         input int e_cycles);
    int lb, acc, cyc, nw;
    lb = wlog.size();
    corrupt_en = cor_en; corrupt_addr = cor_addr;
    stim_q.delete();
    if (fixed) begin
      stim_q.push_back(32'h00404713); stim_q.push_back(32'h00404693); stim_q.push_back(32'h00e696b3);
    end else for (int i = 0; i < count; i++) stim_q.push_back($urandom);
    @(negedge clk);
    start = 1'b1; base_addr = base[29:0]; word_count = count[12:0];
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, ".busy_after_start"}, 32'(busy),
                32'(count != 0 && base + count <= DEPTH));
    applyStimulus(count * 3 + 20, toggle, poke, acc, cyc);
    nw = wlog.size() - lb;
    checkOutput({tag, ".done"}, 32'(done), 32'(e_done));
    checkOutput({tag, ".error"}, 32'(error), 32'(e_err));
    checkOutput({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(!e_done));
    checkOutput({tag, ".busy"}, 32'(busy), 0);
    checkOutput({tag, ".in_ready"}, 32'(in_ready), 0);
    checkOutput({tag, ".words_done"}, 32'(words_done), 32'(e_words));
    checkOutput({tag, ".writes"}, 32'(nw), 32'(e_writes));
    checkOutput({tag, ".handshakes"}, 32'(acc), 32'(e_writes));
    for (int i = 0; i < nw && i < e_writes; i++) begin
      checkOutput({tag, ".wr_addr"}, 32'(wlog[lb + i].addr), 32'(base + i));
      checkOutput({tag, ".wr_data"}, wlog[lb + i].data, stim_q[i]);
    end
    if (e_cycles >= 0) checkOutput({tag, ".cycles"}, 32'(cyc), 32'(e_cycles));
  endtask

  typedef struct {
    string tag; int base; int count; bit toggle; bit fixed; bit cor_en; int cor_addr; int poke;
    bit e_done; bit e_err; int e_words; int e_writes; int e_cycles;
  } vec_t;

  initial begin
    vec_t vecs[$];
    int lb, guard;
    bit md, me; int mw, mwr;

    #2 rst_n = 1'b0;
    #1 checkResetValues("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{"basic3", 0, 3, 0, 1, 0, 0, -1, 1, 0, 3, 3, 3 * CYC_PER_WORD});
    vecs.push_back('{"count0", 100, 0, 0, 0, 0, 0, -1, 1, 0, 0, 0, 0});
    vecs.push_back('{"range_over", 4094, 3, 0, 0, 0, 0, -1, 0, 1, 0, 0, 0});
    vecs.push_back('{"range_edge", 4093, 3, 0, 0, 0, 0, -1, 1, 0, 3, 3, 3 * CYC_PER_WORD});
    vecs.push_back('{"last_word", 4095, 1, 0, 0, 0, 0, -1, 1, 0, 1, 1, CYC_PER_WORD});
    vecs.push_back('{"full_over", 1, 4096, 0, 0, 0, 0, -1, 0, 1, 0, 0, 0});
    vecs.push_back('{"toggle", 10, 8, 1, 0, 0, 0, -1, 1, 0, 8, 8, -1});
    vecs.push_back('{"start_busy", 300, 4, 0, 0, 0, 0, 1, 1, 0, 4, 4, 4 * CYC_PER_WORD});
`ifdef INST_LOADER_VERIFY_EN
    vecs.push_back('{"corrupt", 0, 3, 0, 1, 1, 1, -1, 0, 1, 1, 2, -1});
`else
    vecs.push_back('{"corrupt", 0, 3, 0, 1, 1, 1, -1, 1, 0, 3, 3, 3});
`endif
    vecs.push_back('{"full_depth", 0, 4096, 0, 0, 0, 0, -1, 1, 0, 4096, 4096, 4096 * CYC_PER_WORD});

    foreach (vecs[i])
      runCase(vecs[i].tag, vecs[i].base, vecs[i].count, vecs[i].toggle, vecs[i].fixed,
              vecs[i].cor_en, vecs[i].cor_addr, vecs[i].poke, vecs[i].e_done, vecs[i].e_err,
              vecs[i].e_words, vecs[i].e_writes, vecs[i].e_cycles);

    // Asynchronous reset in the middle of a five-word load
    lb = wlog.size();
    corrupt_en = 1'b0;
    @(negedge clk);
    start = 1'b1; base_addr = 30'd200; word_count = 13'd5;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (wlog.size() < lb + 2 && guard < 40) begin
      in_valid = 1'b1; in_data = $urandom;
      @(negedge clk);
      guard++;
    end
    checkOutput("midreset.pre_writes", 32'(wlog.size() - lb), 2);
    #2 rst_n = 1'b0;
    #1 checkResetValues("midreset");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("midreset.no_more_writes", 32'(wlog.size() - lb), 2);
    runCase("after_reset", 50, 5, 0, 0, 0, 0, -1, 1, 0, 5, 5, 5 * CYC_PER_WORD);

    // Randomised loads against the outcome model
    for (int r = 0; r < 12; r++) begin
      int b, c, ca; bit ce, tg;
      c  = $urandom_range(0, 12);
      if ($urandom_range(0, 2) == 0) begin
        b = DEPTH - c - 1 + int'($urandom_range(0, 2));
        if (b < 0) b = 0;
      end else b = $urandom_range(0, 4000);
      ce = ($urandom_range(0, 1) == 1);
      ca = b + int'($urandom_range(0, (c > 0) ? c - 1 : 0));
      tg = ($urandom_range(0, 1) == 1);
      model(b, c, ce, ca, md, me, mw, mwr);
      runCase($sformatf("rand%0d", r), b, c, tg, 0, ce, ca, -1, md, me, mw, mwr, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
